// File: rtl/alu_pkg.sv
// Shared constants for the MIPS-style ALU: control-code width and opcode encodings.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 3'b101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Shared WIDTH-bit adder/subtractor; subtraction is A + ~B + 1 through the same carry chain.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  assign sum       = full[WIDTH-1:0];
  assign carry_out = full[WIDTH];
  // Using the inverted B covers both ADD and SUB with the same-sign rule.
  assign overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// 32-bit MIPS-style ALU: result mux over logic/arith/compare ops, one registered stage
// carrying Result, Zero and Overflow together.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic [ALU_CTRL_W-1:0] ALUctr,
  output logic [WIDTH-1:0]      Result,
  output logic                  Zero,
  output logic                  Overflow
);

  logic [WIDTH-1:0] sum;
  logic             carry_out, add_ovf, sub;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;

  assign sub = (ALUctr == ALU_SUB) || (ALUctr == ALU_SLT) || (ALUctr == ALU_SLTU);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a         (A),
    .b         (B),
    .sub       (sub),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (add_ovf)
  );

  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (ALUctr)
      ALU_AND:  result_d = A & B;
      ALU_OR:   result_d = A | B;
      ALU_ADD:  begin result_d = sum; overflow_d = add_ovf; end
      ALU_XOR:  result_d = A ^ B;
      ALU_NOR:  result_d = ~(A | B);
      // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
      ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, ~carry_out};
      ALU_SUB:  begin result_d = sum; overflow_d = add_ovf; end
      // Sign of the difference is wrong exactly when the subtraction overflowed.
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default:  result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed vectors, checked #1 after each rising edge.
module tb_alu;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  ALUctr;
  logic [31:0] Result;
  logic        Zero, Overflow;

  int tests = 0;
  int fails = 0;

  alu #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALUctr   (ALUctr),
    .Result   (Result),
    .Zero     (Zero),
    .Overflow (Overflow)
  );

  always #5 clock = ~clock;

  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c);
    reset  = rst;
    A      = a;
    B      = b;
    ALUctr = c;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp_r, input logic exp_o);
    logic exp_z;
    exp_z = (exp_r == 32'd0);
    tests++;
    assert (Result === exp_r) else begin
      fails++;
      $error("FAIL %s result: got %h want %h", tag, Result, exp_r);
    end
    tests++;
    assert (Zero === exp_z) else begin
      fails++;
      $error("FAIL %s zero: got %b want %b", tag, Zero, exp_z);
    end
    tests++;
    assert (Overflow === exp_o) else begin
      fails++;
      $error("FAIL %s overflow: got %b want %b", tag, Overflow, exp_o);
    end
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; ALUctr = '0;

    step(1'b1, 32'd127, 32'd33, ALU_ADD);  chk("rst0", 32'd0, 1'b0);
    step(1'b1, 32'd127, 32'd33, ALU_ADD);  chk("rst1", 32'd0, 1'b0);

    step(1'b0, 32'd127, 32'd33, ALU_AND);  chk("and",  32'd33,  1'b0);
    step(1'b0, 32'd127, 32'd33, ALU_OR);   chk("or",   32'd127, 1'b0);
    step(1'b0, 32'd127, 32'd33, ALU_ADD);  chk("add",  32'd160, 1'b0);
    step(1'b0, 32'd127, 32'd33, ALU_SUB);  chk("sub",  32'd94,  1'b0);
    step(1'b0, 32'd127, 32'd33, ALU_SLT);  chk("slt0", 32'd0,   1'b0);

    step(1'b0, 32'd10, 32'd10, ALU_SUB);             chk("sub_eq",  32'd0, 1'b0);
    step(1'b0, 32'h8000_0000, 32'd1, ALU_SLT);       chk("slt_ovf", 32'd1, 1'b0);
    step(1'b0, 32'h8000_0000, 32'd1, ALU_SLTU);      chk("sltu",    32'd0, 1'b0);
    step(1'b0, 32'd1, 32'h8000_0000, ALU_SLTU);      chk("sltu1",   32'd1, 1'b0);
    step(1'b0, 32'h8000_0000, 32'd1, ALU_SUB);       chk("sub_ovf", 32'h7FFF_FFFF, 1'b1);
    step(1'b0, 32'h7FFF_FFFF, 32'd1, ALU_ADD);       chk("add_ovf", 32'h8000_0000, 1'b1);
    step(1'b0, 32'hFFFF_FFFF, 32'd1, ALU_ADD);       chk("add_wrap", 32'd0, 1'b0);
    step(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_XOR); chk("xor", 32'h0FF0_0FF0, 1'b0);
    step(1'b0, 32'd0, 32'd0, ALU_NOR);               chk("nor", 32'hFFFF_FFFF, 1'b0);

    step(1'b0, 32'd5, 32'd6, ALU_ADD);     chk("pre_rst", 32'd11, 1'b0);
    step(1'b1, 32'h7FFF_FFFF, 32'd1, ALU_ADD); chk("mid_rst", 32'd0, 1'b0);
    step(1'b0, 32'hF, 32'h5, ALU_AND);     chk("post_rst", 32'd5, 1'b0);
    step(1'b0, 32'd3, 32'd7, ALU_SLT);     chk("slt1", 32'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit MIPS-style integer ALU for the single-cycle/pipelined MIPS datapath.
- Computes a logic, arithmetic or compare result of operands A and B, selected by a 3-bit control code from the ALU control decoder.
- Outputs are registered: one clock of latency.
- Also provides a Zero flag for branch resolution and an Overflow flag for signed add/sub.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A (rs).
- B  input  WIDTH  operand B (rt or sign-extended immediate).
- ALUctr  input  3  operation select.
- Result  output  WIDTH  registered operation result.
- Zero  output  1  registered; 1 when the registered Result equals 0.
- Overflow  output  1  registered; signed overflow of ADD/SUB, else 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, sampled at the rising edge:
  - Result <= 0, Zero <= 1, Overflow <= 0.
  - Reset has priority over any operation.
  - Reset asserted mid-stream discards the in-flight result.
- Latency: the operation on A/B/ALUctr sampled at rising edge N appears on the outputs after edge N. Outputs hold until the next edge. No handshake; a new operation is accepted every cycle.
- Operation encoding (ALUctr):
  - 000 AND: A & B
  - 001 OR: A | B
  - 010 ADD: A + B, modulo 2^WIDTH
  - 011 XOR: A ^ B
  - 100 NOR: ~(A | B)
  - 101 SLTU: unsigned A < B -> 1, else 0 (zero-extended)
  - 110 SUB: A - B, modulo 2^WIDTH
  - 111 SLT: signed A < B -> 1, else 0 (zero-extended)
- Arithmetic:
  - ADD and SUB share one adder: SUB = A + ~B + 1.
  - Carry out is discarded.
  - Overflow for ADD: operands have the same sign and the sum sign differs.
  - Overflow for SUB: operands have different signs and the result sign differs from A.
  - Overflow = 0 for all other opcodes.
- SLT must be correct when the subtraction overflows: less = sign(A-B) XOR overflow (e.g. A=0x80000000, B=1 -> 1).
- SLTU uses the adder borrow: less = NOT carry_out of A + ~B + 1.
- Zero is computed from the combinational next result and registered alongside it, so Zero always matches the Result currently on the outputs.
- Wrap-around: 0xFFFFFFFF + 1 = 0, Zero = 1, Overflow = 0. 0x7FFFFFFF + 1 = 0x80000000, Overflow = 1.
- All opcodes are defined; no X propagation from ALUctr.

Decomposition:
- Package alu_pkg:
  - localparams for the 8 ALUctr codes (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SLTU, ALU_SUB, ALU_SLT).
  - ALU_CTRL_W = 3.
- One natural sub-module: alu_addsub.
  - Combinational WIDTH-bit adder/subtractor.
  - Outputs sum, carry_out, overflow.
  - Used for ADD, SUB, SLT and SLTU.
- The top level holds the result mux and the output registers.

Test Plan:
- Reset: assert reset for 2 cycles with A=127, B=33, ALUctr=010 -> Result=0, Zero=1, Overflow=0 after each edge.
- A=127, B=33, sequence AND, OR, ADD, SUB, SLT on consecutive cycles -> one cycle later each: 33, 127, 160, 94, 0. Zero=0 and Overflow=0 throughout.
- A=10, B=10, SUB -> Result=0, Zero=1. A=0x80000000, B=1, SLT -> 1 with Overflow=0 (Overflow is 0 for SLT). SLTU with the same operands -> 0.
- ADD A=0x7FFFFFFF, B=1 -> 0x80000000, Overflow=1. ADD A=0xFFFFFFFF, B=1 -> 0, Zero=1, Overflow=0.
- XOR A=0xF0F0F0F0, B=0xFF00FF00 -> 0x0FF00FF0. NOR A=0, B=0 -> 0xFFFFFFFF, Zero=0.
- Back-to-back ops, then reset asserted for one cycle mid-stream -> outputs cleared on that edge and the next op resumes normally one cycle after reset is released.
